// File: rtl/ddr_arbiter.sv
// ddr_arbiter: round-robin, ownership-based sharing of one host DDR port
// between NUM_CLIENTS internal masters. The owner keeps the port until it
// drops acquire and all of its read beats have returned.
// Optional feature macro: DDR_ARB_TIMEOUT_EN (ownership timeout with preemption).
module ddr_arbiter #(
    parameter int unsigned NUM_CLIENTS     = 2,
    parameter int unsigned MAX_OUTSTANDING = 256,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CLIENTS-1:0]    cl_acquire,
    input  logic [NUM_CLIENTS*29-1:0] cl_addr,
    input  logic [NUM_CLIENTS*64-1:0] cl_wdata,
    input  logic [NUM_CLIENTS-1:0]    cl_read,
    input  logic [NUM_CLIENTS-1:0]    cl_write,
    input  logic [NUM_CLIENTS*8-1:0]  cl_burstcnt,
    input  logic [NUM_CLIENTS*8-1:0]  cl_byteenable,
    output logic [NUM_CLIENTS-1:0]    cl_busy,
    output logic [63:0]               cl_rdata,
    output logic [NUM_CLIENTS-1:0]    cl_rdata_ready,
    output logic                      ddr_acquire,
    output logic [28:0]               ddr_addr,
    output logic [63:0]               ddr_wdata,
    output logic                      ddr_read,
    output logic                      ddr_write,
    output logic [7:0]                ddr_burstcnt,
    output logic [7:0]                ddr_byteenable,
    input  logic [63:0]               ddr_rdata,
    input  logic                      ddr_busy,
    input  logic                      ddr_rdata_ready,
    output logic [NUM_CLIENTS-1:0]    preempted
);

    localparam int unsigned AW = 29;
    localparam int unsigned DW = 64;
    localparam int unsigned BW = 8;
    localparam int unsigned EW = 8;
    localparam int unsigned OW = $clog2(NUM_CLIENTS);
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned SW = CW + BW + 1;

    // Elaboration-time parameter sanity
    if (NUM_CLIENTS < 2 || NUM_CLIENTS > 4) begin : g_bad_clients
        $error("ddr_arbiter: NUM_CLIENTS must be in 2..4");
    end
    if (MAX_OUTSTANDING < 1) begin : g_bad_outstanding
        $error("ddr_arbiter: MAX_OUTSTANDING must be at least 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("ddr_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state;
    logic [OW-1:0] owner;
    logic [OW-1:0] last;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] out_next;
    logic [OW-1:0] winner;
    logic          any_req;

    logic [AW-1:0] own_addr;
    logic [DW-1:0] own_wdata;
    logic [BW-1:0] own_burst;
    logic [EW-1:0] own_be;
    logic          own_read;
    logic          own_write;
    logic          own_acq;
    logic [SW-1:0] sum;
    logic          ovf;

    // Owner's request fields
    assign own_addr  = cl_addr[int'(owner)*AW +: AW];
    assign own_wdata = cl_wdata[int'(owner)*DW +: DW];
    assign own_burst = cl_burstcnt[int'(owner)*BW +: BW];
    assign own_be    = cl_byteenable[int'(owner)*EW +: EW];
    assign own_read  = cl_read[owner];
    assign own_write = cl_write[owner];
    assign own_acq   = cl_acquire[owner];

    // A read that would push the in-flight count past the limit is held off
    assign sum = SW'(outstanding) + SW'(own_burst);
    assign ovf = own_read && (sum > SW'(MAX_OUTSTANDING));

    assign any_req  = |cl_acquire;
    assign cl_rdata = ddr_rdata;

    // Round-robin search starting just after the last winner
    always_comb begin
        logic found;
        found  = 1'b0;
        winner = last;
        for (int unsigned i = 1; i <= NUM_CLIENTS; i++) begin
            if (!found && cl_acquire[OW'((32'(last) + i) % NUM_CLIENTS)]) begin
                found  = 1'b1;
                winner = OW'((32'(last) + i) % NUM_CLIENTS);
            end
        end
    end

    // Host-side muxing and per-client stall/read-valid routing
    always_comb begin
        cl_busy        = '1;
        cl_rdata_ready = '0;
        ddr_acquire    = 1'b0;
        ddr_addr       = '0;
        ddr_wdata      = '0;
        ddr_read       = 1'b0;
        ddr_write      = 1'b0;
        ddr_burstcnt   = '0;
        ddr_byteenable = '0;
        case (state)
            GRANT: begin
                ddr_acquire           = 1'b1;
                ddr_addr              = own_addr;
                ddr_wdata             = own_wdata;
                ddr_burstcnt          = own_burst;
                ddr_byteenable        = own_be;
                ddr_read              = own_read && !ovf;
                ddr_write             = own_write;
                cl_busy[owner]        = ddr_busy || ovf;
                cl_rdata_ready[owner] = ddr_rdata_ready;
            end
            DRAIN: begin
                ddr_acquire           = 1'b1;
                cl_rdata_ready[owner] = ddr_rdata_ready;
            end
            default: ;
        endcase
    end

    // In-flight read beat count; a stray beat at zero is dropped
    always_comb begin
        out_next = outstanding;
        if (ddr_read && !ddr_busy) begin
            out_next = out_next + CW'(own_burst);
        end
        if (ddr_rdata_ready && (outstanding != '0)) begin
            out_next = out_next - CW'(1);
        end
    end

`ifdef DDR_ARB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0]          tmo;
    logic                   tmo_hit;
    logic [NUM_CLIENTS-1:0] others;

    assign tmo_hit = (tmo >= TW'(TIMEOUT_CYCLES - 1));

    // Requests from anyone other than the current owner
    always_comb begin
        others        = cl_acquire;
        others[owner] = 1'b0;
    end
`else
    assign preempted = '0;
`endif

    // Arbitration state machine and counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= '0;
            last        <= OW'(NUM_CLIENTS - 1);
            outstanding <= '0;
`ifdef DDR_ARB_TIMEOUT_EN
            tmo         <= '0;
            preempted   <= '0;
`endif
        end else begin
            outstanding <= out_next;
`ifdef DDR_ARB_TIMEOUT_EN
            preempted   <= '0;
`endif
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner <= winner;
                        last  <= winner;
                        state <= GRANT;
`ifdef DDR_ARB_TIMEOUT_EN
                        tmo   <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (!own_acq) begin
                        state <= DRAIN;
`ifdef DDR_ARB_TIMEOUT_EN
                    end else if (tmo_hit && (|others)) begin
                        state            <= DRAIN;
                        preempted[owner] <= 1'b1;
                    end else if (!tmo_hit) begin
                        tmo <= tmo + TW'(1);
`endif
                    end
                end
                DRAIN: begin
                    if (outstanding == '0) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
